// File: rtl/psum_arb_pkg.sv
// psum_arb_pkg: shared FSM and grant-source enums for the partial-sum memory arbiter
package psum_arb_pkg;
  typedef enum logic [1:0] {ST_NORMAL, ST_DRAIN, ST_DONE} arb_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_DRAIN, SRC_RD, SRC_HOST} grant_src_t;
endpackage

// File: rtl/psum_mem_arbiter_if.sv
// psum_mem_arbiter_if: write-back, read, host and memory signals around the arbiter
interface psum_mem_arbiter_if #(parameter int AW = 20, parameter int DW = 32);
  logic wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_gnt;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic host_req;
  logic [AW-1:0] host_addr;
  logic host_gnt;
  logic [DW-1:0] host_data;
  logic host_valid;
  logic mem_en;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input wr_req, wr_addr, wr_data, rd_req, rd_addr, host_req, host_addr, mem_rdata,
    output rd_gnt, rd_data, rd_valid, host_gnt, host_data, host_valid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, host_req, host_addr, mem_rdata,
    input rd_gnt, rd_data, rd_valid, host_gnt, host_data, host_valid,
    input mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/psum_wbuf.sv
// psum_wbuf: in-order write FIFO with address-match lookup for two read ports
module psum_wbuf #(
  parameter int AW = 20,
  parameter int DW = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [$clog2(DEPTH):0] count,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] host_addr,
  output logic rd_hit,
  output logic host_hit
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] wp, rp;
  // when full, push and pop share a slot: the later set keeps the new entry valid
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[rp] <= 1'b0;
        rp <= rp + 1'b1;
      end
      if (push) begin
        valid[wp] <= 1'b1;
        addr_q[wp] <= push_addr;
        data_q[wp] <= push_data;
        wp <= wp + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_comb begin
    rd_hit = 1'b0;
    host_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_hit = rd_hit | (valid[i] && addr_q[i] == rd_addr);
      host_hit = host_hit | (valid[i] && addr_q[i] == host_addr);
    end
  end
  assign head_addr = addr_q[rp];
  assign head_data = data_q[rp];
endmodule

// File: rtl/psum_mem_arbiter.sv
// psum_mem_arbiter: single-port psum memory shared by buffered write-back, controller reads and host readout
module psum_mem_arbiter import psum_arb_pkg::*; #(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_in,
  psum_mem_arbiter_if.slave bus,
  input  logic flush,
  output logic flush_done,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam int HW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state, state_nx;
  grant_src_t src;
  logic [HW-1:0] host_wait;
  logic [LOG2_OF_MEM_HEIGHT-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic rd_hit, host_hit, empty, forced, starve, rd_ok, host_ok, pop, rd_pend, host_pend;
  psum_wbuf #(.AW(LOG2_OF_MEM_HEIGHT), .DW(DATA_WIDTH), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk),
    .rst(rst_in),
    .push(bus.wr_req),
    .push_addr(bus.wr_addr),
    .push_data(bus.wr_data),
    .pop(pop),
    .head_addr(head_addr),
    .head_data(head_data),
    .count(wbuf_count),
    .rd_addr(bus.rd_addr),
    .host_addr(bus.host_addr),
    .rd_hit(rd_hit),
    .host_hit(host_hit)
  );
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= ST_NORMAL;
      host_wait <= '0;
      rd_pend <= 1'b0;
      host_pend <= 1'b0;
    end else begin
      state <= state_nx;
      host_wait <= (!bus.host_req || bus.host_gnt) ? '0 : starve ? host_wait : host_wait + 1'b1;
      rd_pend <= bus.rd_gnt;
      host_pend <= bus.host_gnt;
    end
  end
  // a read hitting a buffered write falls through to a drain until the hit clears
  always_comb begin
    empty = wbuf_count == '0;
    forced = !empty && (wbuf_count >= CW'(WBUF_DEPTH - 1) || state == ST_DRAIN);
    starve = host_wait == HW'(STARVE_LIMIT);
    rd_ok = bus.rd_req && !rd_hit && state != ST_DRAIN;
    host_ok = bus.host_req && !host_hit && state != ST_DRAIN;
    src = rst_in ? SRC_NONE :
          forced ? SRC_DRAIN :
          (starve && host_ok) ? SRC_HOST :
          (starve && bus.host_req && host_hit) ? SRC_DRAIN :
          rd_ok ? SRC_RD :
          !empty ? SRC_DRAIN :
          host_ok ? SRC_HOST : SRC_NONE;
    pop = src == SRC_DRAIN;
    bus.rd_gnt = src == SRC_RD;
    bus.host_gnt = src == SRC_HOST;
    bus.mem_en = src != SRC_NONE;
    bus.mem_we = pop;
    bus.mem_addr = pop ? head_addr : (src == SRC_RD) ? bus.rd_addr :
                   (src == SRC_HOST) ? bus.host_addr : '0;
    bus.mem_wdata = pop ? head_data : '0;
    bus.rd_valid = rd_pend;
    bus.rd_data = rd_pend ? bus.mem_rdata : '0;
    bus.host_valid = host_pend;
    bus.host_data = host_pend ? bus.mem_rdata : '0;
    state_nx = (state == ST_NORMAL) ? (flush ? ST_DRAIN : ST_NORMAL) :
               (state == ST_DRAIN) ? ((empty && !bus.wr_req) ? ST_DONE : ST_DRAIN) : ST_NORMAL;
    flush_done = state == ST_DONE;
  end
endmodule
